// File: rtl/gelato_types.sv
// Shared Gelato front-end types: the decoded instruction record, RV32 opcode
// constants and the instruction format classifier used by decode.
`include "gelato_macros.svh"

package gelato_types;

  typedef struct packed {
    logic [`GELATO_OPCODE_W-1:0] opcode;
    logic [`GELATO_REG_W-1:0]    rd;
    logic [`GELATO_REG_W-1:0]    rs1;
    logic [`GELATO_REG_W-1:0]    rs2;
    logic [`GELATO_REG_W-1:0]    rs3;
    logic [`GELATO_IMM_W-1:0]    imm;
    logic [`GELATO_FUNCT3_W-1:0] funct3;
    logic [`GELATO_FUNCT7_W-1:0] funct7;
  } gelato_inst_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
  localparam logic [6:0] OPC_FMADD  = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD = 7'b1001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_R4, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
  } inst_fmt_t;

  // The all-zero word and non-32-bit encodings are rejected before the opcode is looked at.
  function automatic inst_fmt_t inst_format(input logic [31:0] inst);
    inst_fmt_t fmt;
    fmt = FMT_ILL;
    if (inst != 32'h0 && inst[1:0] == 2'b11) begin
      case (inst[6:0])
        OPC_OP, OPC_OP_FP:                          fmt = FMT_R;
        OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: fmt = FMT_R4;
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
        OPC_STORE:                                  fmt = FMT_S;
        OPC_BRANCH:                                 fmt = FMT_B;
        OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
        OPC_JAL:                                    fmt = FMT_J;
        default:                                    fmt = FMT_ILL;
      endcase
    end
    return fmt;
  endfunction

endpackage

// File: rtl/gelato_inst_field_decode.sv
// Combinational field extraction: raw instruction word -> gelato_inst_t plus
// illegal flag. Fields a format does not use are forced to zero so issue never
// sees stale register numbers.
module gelato_inst_field_decode
  import gelato_types::*;
(
  input  logic [31:0]  inst,
  output gelato_inst_t fields,
  output logic         illegal
);

  inst_fmt_t fmt;

  // Classify the word, then keep only the fields its format defines.
  // U-type keeps rd (the destination of LUI/AUIPC) and drops the source fields.
  always_comb begin
    fields  = '0;
    illegal = 1'b0;
    fmt     = inst_format(inst);
    fields.opcode = inst[6:0];
    case (fmt)
      FMT_R: begin
        fields.rd     = inst[11:7];
        fields.funct3 = inst[14:12];
        fields.rs1    = inst[19:15];
        fields.rs2    = inst[24:20];
        fields.funct7 = inst[31:25];
      end
      FMT_R4: begin
        fields.rd     = inst[11:7];
        fields.funct3 = inst[14:12];
        fields.rs1    = inst[19:15];
        fields.rs2    = inst[24:20];
        fields.rs3    = inst[31:27];
        fields.funct7 = {5'b0, inst[26:25]};
      end
      FMT_I: begin
        fields.rd     = inst[11:7];
        fields.funct3 = inst[14:12];
        fields.rs1    = inst[19:15];
        fields.imm    = {{20{inst[31]}}, inst[31:20]};
        if (inst[6:0] == OPC_OP_IMM && (inst[14:12] == 3'b001 || inst[14:12] == 3'b101))
          fields.funct7 = inst[31:25];
      end
      FMT_S: begin
        fields.funct3 = inst[14:12];
        fields.rs1    = inst[19:15];
        fields.rs2    = inst[24:20];
        fields.imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      FMT_B: begin
        fields.funct3 = inst[14:12];
        fields.rs1    = inst[19:15];
        fields.rs2    = inst[24:20];
        fields.imm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      FMT_U: begin
        fields.rd     = inst[11:7];
        fields.imm    = {inst[31:12], 12'b0};
      end
      FMT_J: begin
        fields.rd     = inst[11:7];
        fields.imm    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/gelato_macros.svh
// Field widths of the decoded instruction record shared across the Gelato front end.
`ifndef GELATO_MACROS_SVH
`define GELATO_MACROS_SVH

`define GELATO_OPCODE_W 7
`define GELATO_REG_W    5
`define GELATO_IMM_W    32
`define GELATO_FUNCT3_W 3
`define GELATO_FUNCT7_W 7

`endif

// File: rtl/gelato_inst_decoder.sv
// Gelato decode stage: valid/ready wrapper around gelato_inst_field_decode with
// a registered output stage and one-entry skid buffer so fetch ready is a flop.
// Optional feature: define GELATO_DECODE_STATS_EN to add stat_decoded/stat_illegal counters.
module gelato_inst_decoder
  import gelato_types::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output gelato_inst_t        out_inst,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_illegal
`ifdef GELATO_DECODE_STATS_EN
  ,
  output logic [31:0]         stat_decoded,
  output logic [31:0]         stat_illegal
`endif
);

  typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;

  state_t              state;
  gelato_inst_t        dec_inst;
  logic                dec_illegal;
  gelato_inst_t        skid_inst;
  logic [PC_WIDTH-1:0] skid_pc;
  logic                skid_illegal;
  logic                in_fire;
  logic                out_fire;

  gelato_inst_field_decode u_field_decode (
    .inst    (in_inst),
    .fields  (dec_inst),
    .illegal (dec_illegal)
  );

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Handshake FSM: the output register is always the FIFO head, the skid register
  // only fills when issue stalls while a new word arrives; flush beats everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      out_inst     <= '0;
      out_pc       <= '0;
      out_illegal  <= 1'b0;
      skid_inst    <= '0;
      skid_pc      <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            out_inst    <= dec_inst;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal;
            out_valid   <= 1'b1;
            state       <= FULL1;
          end
        end
        FULL1: begin
          if (in_fire && !out_fire) begin
            skid_inst    <= dec_inst;
            skid_pc      <= in_pc;
            skid_illegal <= dec_illegal;
            in_ready     <= 1'b0;
            state        <= FULL2;
          end else if (in_fire) begin
            out_inst    <= dec_inst;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL2: begin
          if (out_fire) begin
            out_inst    <= skid_inst;
            out_pc      <= skid_pc;
            out_illegal <= skid_illegal;
            in_ready    <= 1'b1;
            state       <= FULL1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef GELATO_DECODE_STATS_EN
  // Retired-record counters; they survive flush so redirects do not lose history.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (out_fire) begin
      stat_decoded <= stat_decoded + 32'd1;
      if (out_illegal)
        stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gelato_inst_decoder.sv
// Directed bench for gelato_inst_decoder: decode of each format, illegal words,
// backpressure through the skid buffer, flush and mid-operation reset.
module tb_gelato_inst_decoder;
  import gelato_types::*;

  localparam int PC_WIDTH = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  gelato_inst_t        out_inst;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_illegal;
`ifdef GELATO_DECODE_STATS_EN
  logic [31:0]         stat_decoded;
  logic [31:0]         stat_illegal;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  logic [31:0]  vinst [11];
  gelato_inst_t vexp  [11];
  logic         vill  [11];

  always #5 clk = ~clk;

  gelato_inst_decoder #(.PC_WIDTH(PC_WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
`ifdef GELATO_DECODE_STATS_EN
    ,
    .stat_decoded(stat_decoded),
    .stat_illegal(stat_illegal)
`endif
  );

  function automatic gelato_inst_t mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rs3, input logic [31:0] imm,
                                      input logic [2:0] f3, input logic [6:0] f7);
    gelato_inst_t r;
    r.opcode = op;  r.rd = rd;   r.rs1 = rs1;   r.rs2 = rs2;
    r.rs3 = rs3;    r.imm = imm; r.funct3 = f3; r.funct7 = f7;
    return r;
  endfunction

  // Drive one cycle of fetch inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence; every expected value below was worked out by hand.
  initial begin
    vinst[0]  = 32'h00510093; vexp[0]  = mk(7'h13, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00000005, 3'd0, 7'h00); vill[0]  = 1'b0;
    vinst[1]  = 32'h123452B7; vexp[1]  = mk(7'h37, 5'd5, 5'd0, 5'd0, 5'd0, 32'h12345000, 3'd0, 7'h00); vill[1]  = 1'b0;
    vinst[2]  = 32'hFE000EE3; vexp[2]  = mk(7'h63, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 3'd0, 7'h00); vill[2]  = 1'b0;
    vinst[3]  = 32'h00000000; vexp[3]  = mk(7'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'd0, 7'h00); vill[3]  = 1'b1;
    vinst[4]  = 32'h0000007F; vexp[4]  = mk(7'h7F, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'd0, 7'h00); vill[4]  = 1'b1;
    vinst[5]  = 32'h002081B3; vexp[5]  = mk(7'h33, 5'd3, 5'd1, 5'd2, 5'd0, 32'h00000000, 3'd0, 7'h00); vill[5]  = 1'b0;
    vinst[6]  = 32'h0020A423; vexp[6]  = mk(7'h23, 5'd0, 5'd1, 5'd2, 5'd0, 32'h00000008, 3'd2, 7'h00); vill[6]  = 1'b0;
    vinst[7]  = 32'h008000EF; vexp[7]  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 5'd0, 32'h00000008, 3'd0, 7'h00); vill[7]  = 1'b0;
    vinst[8]  = 32'h40315093; vexp[8]  = mk(7'h13, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00000403, 3'd5, 7'h20); vill[8]  = 1'b0;
    vinst[9]  = 32'h203100C3; vexp[9]  = mk(7'h43, 5'd1, 5'd2, 5'd3, 5'd4, 32'h00000000, 3'd0, 7'h00); vill[9]  = 1'b0;
    vinst[10] = 32'h0000000B; vexp[10] = mk(7'h0B, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'd0, 7'h00); vill[10] = 1'b1;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_inst", out_inst, '0);
    checkOutput("rst_out_pc", out_pc, '0);
    checkOutput("rst_out_illegal", out_illegal, 1'b0);
    rst = 1'b0;

    $display("[TB] streaming decode vectors");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, vinst[i], 32'h100 + 32'(4 * i));
      checkOutput($sformatf("stream_valid_%0d", i), out_valid, 1'b1);
      checkOutput($sformatf("stream_inst_%0d", i), out_inst, vexp[i]);
      checkOutput($sformatf("stream_illegal_%0d", i), out_illegal, vill[i]);
      checkOutput($sformatf("stream_pc_%0d", i), out_pc, 32'h100 + 32'(4 * i));
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("stream_drained", out_valid, 1'b0);
`ifdef GELATO_DECODE_STATS_EN
    checkOutput("stat_decoded_stream", stat_decoded, 32'd11);
    checkOutput("stat_illegal_stream", stat_illegal, 32'd3);
`endif

    $display("[TB] backpressure through skid buffer");
    out_ready = 1'b0;
    applyStimulus(1'b1, vinst[0], 32'h200);
    checkOutput("bp_a_inst", out_inst, vexp[0]);
    checkOutput("bp_a_ready", in_ready, 1'b1);
    applyStimulus(1'b1, vinst[1], 32'h204);
    checkOutput("bp_full2_ready", in_ready, 1'b0);
    checkOutput("bp_hold_inst", out_inst, vexp[0]);
    applyStimulus(1'b1, vinst[5], 32'h208);
    checkOutput("bp_hold_ready", in_ready, 1'b0);
    checkOutput("bp_hold_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    applyStimulus(1'b1, vinst[5], 32'h208);
    checkOutput("bp_b_inst", out_inst, vexp[1]);
    checkOutput("bp_b_pc", out_pc, 32'h204);
    checkOutput("bp_b_ready", in_ready, 1'b1);
    applyStimulus(1'b1, vinst[5], 32'h208);
    checkOutput("bp_c_inst", out_inst, vexp[5]);
    checkOutput("bp_c_pc", out_pc, 32'h208);
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("bp_drained", out_valid, 1'b0);

    $display("[TB] flush from FULL2 and FULL1");
    out_ready = 1'b0;
    applyStimulus(1'b1, vinst[0], 32'h300);
    applyStimulus(1'b1, vinst[1], 32'h304);
    checkOutput("fl2_full_ready", in_ready, 1'b0);
    flush = 1'b1;
    applyStimulus(1'b1, vinst[5], 32'h308);
    flush = 1'b0;
    checkOutput("fl2_out_valid", out_valid, 1'b0);
    checkOutput("fl2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("fl2_no_ghost", out_valid, 1'b0);
    out_ready = 1'b0;
    applyStimulus(1'b1, vinst[7], 32'h400);
    flush = 1'b1;
    applyStimulus(1'b1, vinst[6], 32'h404);
    flush = 1'b0;
    checkOutput("fl1_out_valid", out_valid, 1'b0);
    checkOutput("fl1_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("fl1_no_ghost", out_valid, 1'b0);
    applyStimulus(1'b1, vinst[6], 32'h408);
    checkOutput("post_flush_inst", out_inst, vexp[6]);
    checkOutput("post_flush_pc", out_pc, 32'h408);
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("post_flush_drained", out_valid, 1'b0);
`ifdef GELATO_DECODE_STATS_EN
    checkOutput("stat_decoded_flush", stat_decoded, 32'd15);
    checkOutput("stat_illegal_flush", stat_illegal, 32'd3);
`endif

    $display("[TB] reset while holding entries");
    out_ready = 1'b0;
    applyStimulus(1'b1, vinst[8], 32'h500);
    applyStimulus(1'b1, vinst[9], 32'h504);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    checkOutput("mid_rst_out_valid", out_valid, 1'b0);
    checkOutput("mid_rst_in_ready", in_ready, 1'b1);
    checkOutput("mid_rst_out_inst", out_inst, '0);
    checkOutput("mid_rst_out_pc", out_pc, '0);
`ifdef GELATO_DECODE_STATS_EN
    checkOutput("stat_decoded_rst", stat_decoded, 32'd0);
    checkOutput("stat_illegal_rst", stat_illegal, 32'd0);
`endif
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput("mid_rst_no_ghost", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
